// File: rtl/mandel_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
// mandel_frame_ctrl_if : datapath control + pixel result handshake bundle
// Rev 1.0
// ============================================================================
interface mandel_frame_ctrl_if #(
  parameter int CW = 32,
  parameter int XW = 10,
  parameter int YW = 9,
  parameter int IW = 8
);
  logic          dp_ld;
  logic          dp_en;
  logic [CW-1:0] dp_cr;
  logic [CW-1:0] dp_ci;
  logic          dp_diverged;
  logic          pix_valid;
  logic          pix_ready;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic [IW-1:0] pix_iter;

  modport master (
    output dp_ld, dp_en, dp_cr, dp_ci,
    input  dp_diverged,
    output pix_valid, pix_x, pix_y, pix_iter,
    input  pix_ready
  );

  modport slave (
    input  dp_ld, dp_en, dp_cr, dp_ci,
    output dp_diverged,
    input  pix_valid, pix_x, pix_y, pix_iter,
    output pix_ready
  );
endinterface
`default_nettype wire

// File: rtl/mandel_frame_ctrl.sv
`default_nettype none
// ============================================================================
// mandel_frame_ctrl : rasters a frame, drives the Mandelbrot datapath per pixel
// Rev 1.0
// ============================================================================
module mandel_frame_ctrl #(
  parameter int WIDTH    = 640,
  parameter int HEIGHT   = 480,
  parameter int MAX_ITER = 255,
  parameter int CW       = 32,
  parameter int IW       = 8
) (
  input  wire logic           clk,
  input  wire logic           rst,
  input  wire logic           start_i,
  input  wire logic [CW-1:0]  re_origin_i,
  input  wire logic [CW-1:0]  im_origin_i,
  input  wire logic [CW-1:0]  step_i,
  output      logic           busy_o,
  output      logic           frame_done_o,
  mandel_frame_ctrl_if.master dp_if
);

  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [XW-1:0] X_LAST   = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(HEIGHT - 1);
  localparam logic [IW-1:0] ITER_CAP = IW'(MAX_ITER);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_ITER = 3'd2;
  localparam logic [2:0] S_OUT  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]    state_q,    state_d;
  logic [XW-1:0] x_q,        x_d;
  logic [YW-1:0] y_q,        y_d;
  logic [IW-1:0] iter_q,     iter_d;
  logic [IW-1:0] pix_iter_q, pix_iter_d;
  logic [CW-1:0] cr_q,       cr_d;
  logic [CW-1:0] ci_q,       ci_d;
  logic [CW-1:0] re_org_q,   re_org_d;
  logic [CW-1:0] step_q,     step_d;

  // Advance only while neither exit condition holds; dp_diverged is live from z.
  logic iter_live;
  assign iter_live = (state_q == S_ITER) && !dp_if.dp_diverged && (iter_q != ITER_CAP);

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    iter_d     = iter_q;
    pix_iter_d = pix_iter_q;
    cr_d       = cr_q;
    ci_d       = ci_q;
    re_org_d   = re_org_q;
    step_d     = step_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          re_org_d = re_origin_i;
          step_d   = step_i;
          x_d      = '0;
          y_d      = '0;
          cr_d     = re_origin_i;
          ci_d     = im_origin_i;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        iter_d  = '0;
        state_d = S_ITER;
      end
      S_ITER: begin
        if (dp_if.dp_diverged) begin
          pix_iter_d = iter_q;
          state_d    = S_OUT;
        end else if (iter_q == ITER_CAP) begin
          pix_iter_d = ITER_CAP;
          state_d    = S_OUT;
        end else begin
          iter_d = iter_q + 1'b1;
        end
      end
      S_OUT: begin
        if (dp_if.pix_ready) begin
          if (x_q != X_LAST) begin
            x_d     = x_q + 1'b1;
            cr_d    = cr_q + step_q;
            state_d = S_LOAD;
          end else if (y_q != Y_LAST) begin
            x_d     = '0;
            cr_d    = re_org_q;
            y_d     = y_q + 1'b1;
            ci_d    = ci_q + step_q;
            state_d = S_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      iter_q     <= '0;
      pix_iter_q <= '0;
      cr_q       <= '0;
      ci_q       <= '0;
      re_org_q   <= '0;
      step_q     <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      iter_q     <= iter_d;
      pix_iter_q <= pix_iter_d;
      cr_q       <= cr_d;
      ci_q       <= ci_d;
      re_org_q   <= re_org_d;
      step_q     <= step_d;
    end
  end

  assign dp_if.dp_ld     = (state_q == S_LOAD);
  assign dp_if.dp_en     = iter_live;
  assign dp_if.dp_cr     = cr_q;
  assign dp_if.dp_ci     = ci_q;
  assign dp_if.pix_valid = (state_q == S_OUT);
  assign dp_if.pix_x     = x_q;
  assign dp_if.pix_y     = y_q;
  assign dp_if.pix_iter  = pix_iter_q;
  assign busy_o          = (state_q != S_IDLE);
  assign frame_done_o    = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_mandel_frame_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mandel_frame_ctrl : directed bench with a counting datapath model
// Rev 1.0
// ============================================================================
module tb_mandel_frame_ctrl;
  localparam int W = 4, H = 2, MI = 15, CW = 32, IW = 4, XW = 2, YW = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] re_o, im_o, stp;
  logic          busy, fd;

  mandel_frame_ctrl_if #(.CW(CW), .XW(XW), .YW(YW), .IW(IW)) bus ();

  mandel_frame_ctrl #(.WIDTH(W), .HEIGHT(H), .MAX_ITER(MI), .CW(CW), .IW(IW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .re_origin_i  (re_o),
    .im_origin_i  (im_o),
    .step_i       (stp),
    .busy_o       (busy),
    .frame_done_o (fd),
    .dp_if        (bus.master)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: diverges once thresh dp_en pulses have occurred since dp_ld.
  int thresh = 99;
  int en_cnt = 0;
  int fd_total = 0;
  bit both_hi = 1'b0;
  logic [CW-1:0] ld_cr[$], ld_ci[$];
  int xf_x[$], xf_y[$], xf_it[$], xf_en[$];

  assign bus.dp_diverged = (en_cnt >= thresh);

  always @(posedge clk) begin
    if (bus.dp_ld) begin
      ld_cr.push_back(bus.dp_cr);
      ld_ci.push_back(bus.dp_ci);
      en_cnt <= 0;
    end else if (bus.dp_en) begin
      en_cnt <= en_cnt + 1;
    end
    if (bus.dp_ld && bus.dp_en) both_hi <= 1'b1;
    if (fd) fd_total <= fd_total + 1;
    if (bus.pix_valid && bus.pix_ready) begin
      xf_x.push_back(int'(bus.pix_x));
      xf_y.push_back(int'(bus.pix_y));
      xf_it.push_back(int'(bus.pix_iter));
      xf_en.push_back(en_cnt);
    end
  end

  int n_checks = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [CW-1:0] r, input logic [CW-1:0] i, input logic [CW-1:0] s);
    re_o  = r;
    im_o  = i;
    stp   = s;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_fd(input int maxc, input string tag);
    int k = 0;
    while (!fd && k < maxc) begin
      tick();
      k++;
    end
    chk(tag, {31'd0, fd}, 32'd1);
  endtask

  task automatic wait_valid(input int maxc, input string tag);
    int k = 0;
    while (!bus.pix_valid && k < maxc) begin
      tick();
      k++;
    end
    chk(tag, {31'd0, bus.pix_valid}, 32'd1);
  endtask

  task automatic wait_lds(input int target, input int maxc, input string tag);
    int k = 0;
    while (ld_cr.size() < target && k < maxc) begin
      tick();
      k++;
    end
    chk(tag, 32'(ld_cr.size() >= target), 32'd1);
  endtask

  logic [CW-1:0] cr_a[4] = '{32'hE000_0000, 32'hD800_0000, 32'hD000_0000, 32'hC800_0000};
  logic [CW-1:0] ci_a[2] = '{32'h1000_0000, 32'h0800_0000};
  logic [CW-1:0] cr_d[4] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0001, 32'h8000_0002};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bl, bx, fd0, nld, nx, lat;
    bit stable;

    rst = 1'b1; start = 1'b0; re_o = '0; im_o = '0; stp = '0;
    bus.pix_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_busy",  {31'd0, busy}, 0);
    chk("rst_valid", {31'd0, bus.pix_valid}, 0);
    chk("rst_ld",    {31'd0, bus.dp_ld}, 0);
    chk("rst_en",    {31'd0, bus.dp_en}, 0);
    chk("rst_fd",    {31'd0, fd}, 0);
    chk("rst_x",     32'(bus.pix_x), 0);
    chk("rst_y",     32'(bus.pix_y), 0);
    chk("rst_iter",  32'(bus.pix_iter), 0);
    chk("rst_cr",    bus.dp_cr, 0);
    chk("rst_ci",    bus.dp_ci, 0);

    // A: never diverges, raster arithmetic with a negative step (Q4.28)
    thresh = 99; bus.pix_ready = 1'b1;
    bl = ld_cr.size(); bx = xf_x.size(); fd0 = fd_total;
    pulse_start(32'hE000_0000, 32'h1000_0000, 32'hF800_0000);
    wait_fd(400, "A_done");
    chk("A_busy_in_done", {31'd0, busy}, 1);
    tick();
    chk("A_idle_after", {31'd0, busy}, 0);
    chk("A_fd_clear", {31'd0, fd}, 0);
    chk("A_fd_count", fd_total - fd0, 1);
    chk("A_xfers", xf_x.size() - bx, 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("A_x%0d", i),  xf_x[bx+i], i % 4);
      chk($sformatf("A_y%0d", i),  xf_y[bx+i], i / 4);
      chk($sformatf("A_it%0d", i), xf_it[bx+i], 15);
      chk($sformatf("A_en%0d", i), xf_en[bx+i], 15);
      chk($sformatf("A_cr%0d", i), ld_cr[bl+i], cr_a[i%4]);
      chk($sformatf("A_ci%0d", i), ld_ci[bl+i], ci_a[i/4]);
    end
    chk("A_ld_en_overlap", {31'd0, both_hi}, 0);

    // B: divergence after 3 iterations, latency from dp_ld to pix_valid
    thresh = 3;
    bx = xf_x.size(); fd0 = fd_total;
    pulse_start(32'h0, 32'h0, 32'h0100_0000);
    chk("B_ld", {31'd0, bus.dp_ld}, 1);
    lat = 0;
    while (!bus.pix_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("B_latency", lat, 5);
    chk("B_iter", 32'(bus.pix_iter), 3);
    wait_fd(200, "B_done");
    tick();
    chk("B_en_pix0", xf_en[bx], 3);
    chk("B_it_pix7", xf_it[bx+7], 3);
    chk("B_xfers", xf_x.size() - bx, 8);
    chk("B_fd_count", fd_total - fd0, 1);

    // C: backpressure held at pixel (1,0)
    thresh = 2; bus.pix_ready = 1'b0;
    pulse_start(32'h0, 32'h0, 32'h10);
    wait_valid(20, "C_valid0");
    chk("C_x0", 32'(bus.pix_x), 0);
    bus.pix_ready = 1'b1;
    tick();
    bus.pix_ready = 1'b0;
    wait_valid(20, "C_valid1");
    chk("C_x1", 32'(bus.pix_x), 1);
    chk("C_y1", 32'(bus.pix_y), 0);
    nld = ld_cr.size();
    stable = 1'b1;
    repeat (10) begin
      tick();
      if (!(bus.pix_valid && bus.pix_x == 2'd1 && bus.pix_y == 1'b0 &&
            bus.pix_iter == 4'd2 && !bus.dp_ld)) stable = 1'b0;
    end
    chk("C_stable", {31'd0, stable}, 1);
    chk("C_no_ld", ld_cr.size() - nld, 0);
    nx = xf_x.size();
    bus.pix_ready = 1'b1;
    tick();
    chk("C_valid_drop", {31'd0, bus.pix_valid}, 0);
    chk("C_reload", {31'd0, bus.dp_ld}, 1);
    chk("C_one_xfer", xf_x.size() - nx, 1);
    wait_fd(200, "C_done");
    tick();

    // D: wrap of cr, and a start mid-frame must be ignored
    thresh = 0;
    bl = ld_cr.size(); fd0 = fd_total;
    pulse_start(32'h7FFF_FFFF, 32'h0, 32'h1);
    wait_lds(bl + 2, 40, "D_mid");
    pulse_start(32'h100, 32'h200, 32'h5);
    wait_fd(200, "D_done");
    tick();
    chk("D_fd_pulse", {31'd0, fd}, 0);
    tick();
    chk("D_no_restart", {31'd0, busy}, 0);
    chk("D_lds", ld_cr.size() - bl, 8);
    chk("D_fd_count", fd_total - fd0, 1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("D_cr%0d", i), ld_cr[bl+i], cr_d[i%4]);
      chk($sformatf("D_ci%0d", i), ld_ci[bl+i], 32'(i / 4));
    end

    // E: reset during ITER of pixel (2,0) aborts the frame
    thresh = 99;
    bl = ld_cr.size();
    pulse_start(32'h1111_0000, 32'h2222_0000, 32'h0001_0000);
    wait_lds(bl + 3, 100, "E_reach");
    repeat (3) tick();
    chk("E_in_iter", {31'd0, bus.dp_en}, 1);
    fd0 = fd_total;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("E_busy", {31'd0, busy}, 0);
    chk("E_valid", {31'd0, bus.pix_valid}, 0);
    chk("E_en", {31'd0, bus.dp_en}, 0);
    repeat (5) tick();
    chk("E_no_fd", fd_total - fd0, 0);
    chk("E_idle", {31'd0, busy}, 0);
    thresh = 0;
    bl = ld_cr.size(); bx = xf_x.size();
    pulse_start(32'h1234_5678, 32'h0, 32'h10);
    wait_fd(200, "E_done");
    tick();
    chk("E_cr0", ld_cr[bl], 32'h1234_5678);
    chk("E_cr1", ld_cr[bl+1], 32'h1234_5688);
    chk("E_x0", xf_x[bx], 0);
    chk("E_y0", xf_y[bx], 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mandel_frame_ctrl.md
Name: mandel_frame_ctrl

Overview:
- Frame-level scheduler for the Mandelbrot iteration datapath (generator plus the z update and divergence compare).
- Rasters a WIDTH x HEIGHT pixel grid and computes each pixel's constant c = (cr, ci) from a latched origin and step.
- For each pixel it loads the datapath, enables iterations until the divergence flag or MAX_ITER, then emits the iteration count over a valid/ready handshake.
- Sits between the host/config side and the pixel writer.

Parameters:
- WIDTH, 640, pixels per row (>=1)
- HEIGHT, 480, rows per frame (>=1)
- MAX_ITER, 255, iteration cap per pixel (>=1)
- CW, 32, fixed-point width of cr/ci/origin/step (two's complement, same format as the datapath)
- IW, 8, width of the iteration count; must satisfy 2^IW > MAX_ITER

Ports:
- clk  in  1  clock
- rst  in  1  reset. Synchronous, active-high.
- start  in  1  frame start pulse; honoured only in IDLE
- re_origin  in  CW  cr of pixel (0,0); latched on accepted start
- im_origin  in  CW  ci of pixel (0,0); latched on accepted start
- step  in  CW  per-pixel increment, added to cr per column and to ci per row; latched on accepted start
- dp_ld  out  1  datapath load: clears z to 0 and captures dp_cr/dp_ci
- dp_en  out  1  datapath advance one iteration (z <= z^2 + c) at this clock edge
- dp_cr  out  CW  current pixel cr
- dp_ci  out  CW  current pixel ci
- dp_diverged  in  1  combinational from the datapath; reflects the z currently registered
- pix_valid  out  1  result available
- pix_ready  in  1  consumer accepts the result
- pix_x  out  clog2(WIDTH)  result column
- pix_y  out  clog2(HEIGHT)  result row
- pix_iter  out  IW  iteration count
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse after the last pixel is accepted

Behaviour:
- Reset state:
  - state = IDLE.
  - All outputs are 0: dp_ld, dp_en, pix_valid, busy, frame_done, pix_x, pix_y, pix_iter, dp_cr, dp_ci.
  - Internal x, y and iter = 0.
- Reset mid-operation aborts the frame immediately. The result in flight is dropped and no frame_done is produced.
- IDLE:
  - On start=1, latch re_origin, im_origin and step.
  - Set x=0, y=0, dp_cr=re_origin, dp_ci=im_origin.
  - Go to LOAD.
- LOAD (exactly 1 cycle): dp_ld=1, dp_en=0, iter<=0, then go to ITER.
- ITER, evaluated each cycle in this priority order:
  - dp_diverged=1: pix_iter<=iter, dp_en=0, go to OUT.
  - else iter==MAX_ITER: pix_iter<=MAX_ITER, dp_en=0, go to OUT.
  - else dp_en=1 and iter<=iter+1.
  - The iter==0 check happens on the cycle after load, so a pixel whose |c|-test already fires reports 0.
- Latency: a pixel reporting n takes LOAD(1) + ITER(n+1) cycles. pix_valid rises n+2 cycles after LOAD is entered. The minimum pixel period is n+3 cycles with pix_ready held high.
- OUT:
  - pix_valid=1; pix_x, pix_y and pix_iter are stable while valid.
  - Outputs are held indefinitely while pix_ready=0.
  - A transfer occurs on the edge where pix_valid && pix_ready; pix_valid drops the next cycle.
- On transfer, the raster advances:
  - x<WIDTH-1: x++, dp_cr+=step, go to LOAD.
  - x==WIDTH-1 and y<HEIGHT-1: x=0, dp_cr=re_origin, y++, dp_ci+=step, go to LOAD.
  - x==WIDTH-1 and y==HEIGHT-1: go to DONE.
- DONE: frame_done=1 for one cycle, busy still 1, then go to IDLE.
- Arithmetic: cr/ci additions are CW-bit two's complement and wrap modulo 2^CW, with no saturation. Callers pass a negative step for top-down scan. iter never exceeds MAX_ITER.
- start while busy is ignored and does not alter latched values. start in the same cycle as the DONE->IDLE transition is ignored; start is sampled only when state==IDLE.
- dp_diverged is ignored outside ITER.
- dp_ld and dp_en are never high in the same cycle.

Test Plan:
- Common bench settings: WIDTH=4, HEIGHT=2, MAX_ITER=15, IW=4.
- Reset mid-ITER: assert rst for 1 cycle during pixel (2,0) -> next cycle state IDLE, busy=0, pix_valid=0, no frame_done; a new start restarts at (0,0) with re_origin.
- Single pixel, early divergence: model dp_diverged=1 after exactly 3 dp_en pulses, pix_ready=1 -> pix_iter=3; pix_valid rises 5 cycles after dp_ld; exactly 3 dp_en cycles observed.
- Never diverges: dp_diverged=0 always -> every pixel pix_iter=15, 15 dp_en pulses per pixel; frame_done after 8 transfers with coords (0,0)..(3,0),(0,1)..(3,1) in order.
- Raster arithmetic: re_origin=-2.0, im_origin=+1.0, step=-0.5 in the datapath format -> dp_cr sequence -2.0,-2.5,-3.0,-3.5 then back to -2.0 on row 1; dp_ci +1.0 then +0.5; wrap checked with re_origin=0x7FFFFFFF, step=1 giving 0x80000000.
- Backpressure: hold pix_ready=0 for 10 cycles at pixel (1,0) -> pix_valid, pix_x=1, pix_y=0 and pix_iter stable; no dp_ld; one transfer on release, then LOAD.
- start ignored while busy: pulse start with different origin mid-frame -> no restart; remaining dp_cr values follow the original origin; frame_done a single 1-cycle pulse.
